// File: rtl/posit_extract_arbiter_pkg.sv
// Shared definitions for the posit field-extraction arbiter: width helpers,
// source-index width and the special posit bit patterns.
package posit_extract_arbiter_pkg;

    // Number of requesters sharing the datapath is two, so one index bit.
    localparam int SRC_W = 1;

    // Smallest r with 2**r >= value; used to size the regime run-length field.
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // NaR pattern for an n-bit posit: a one in the sign position, zeros below.
    function automatic logic [63:0] nar_pattern(input int n);
        return 64'd1 << (n - 1);
    endfunction

    // Zero pattern for an n-bit posit: all n bits clear.
    function automatic logic [63:0] zero_pattern(input int n);
        return ((64'd1 << n) - 64'd1) & 64'd0;
    endfunction

endpackage

// File: rtl/posit_extract_arbiter_if.sv
// Handshake bundle of the posit extraction arbiter: two requester ports and
// the decoded-result port. The slave modport is the arbiter's view.
interface posit_extract_arbiter_if
    import posit_extract_arbiter_pkg::*;
#(
    parameter int N  = 16,
    parameter int ES = 2
);
    localparam int BS = log2_ceil(N);

    logic [N-1:0]     in0_data;
    logic             in0_valid;
    logic             in0_ready;
    logic [N-1:0]     in1_data;
    logic             in1_valid;
    logic             in1_ready;
    logic             out_valid;
    logic             out_ready;
    logic [SRC_W-1:0] out_src;
    logic             out_sign;
    logic             out_zero;
    logic             out_nar;
    logic [BS:0]      out_k;
    logic [ES-1:0]    out_exp;
    logic [N-ES-1:0]  out_mant;

    modport slave (
        input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
        output in0_ready, in1_ready, out_valid, out_src, out_sign,
        output out_zero, out_nar, out_k, out_exp, out_mant
    );

    modport master (
        output in0_data, in0_valid, in1_data, in1_valid, out_ready,
        input  in0_ready, in1_ready, out_valid, out_src, out_sign,
        input  out_zero, out_nar, out_k, out_exp, out_mant
    );

endinterface

// File: rtl/posit_extract_arbiter_regime_decode.sv
// Combinational regime/exponent/mantissa decode of a posit magnitude with the
// sign bit already stripped. Bits shifted in past the end of the word read 0.
module posit_regime_decode
    import posit_extract_arbiter_pkg::*;
#(
    parameter int N  = 16,
    parameter int ES = 2,
    parameter int BS = log2_ceil(N)
) (
    input  logic [N-2:0]    body_i,
    output logic [BS:0]     k_o,
    output logic [ES-1:0]   exp_o,
    output logic [N-ES-1:0] mant_o
);
    localparam int BW = N - 1;

    logic          lead_s;
    logic [BW-1:0] flip_s;
    logic [BS-1:0] run_s;
    logic          hit_s;
    logic [BS:0]   shamt_s;
    logic [BW-1:0] shifted_s;

    // Leading-run length: invert a ones-run so both cases become a zero count.
    always_comb begin
        lead_s = body_i[BW-1];
        flip_s = lead_s ? ~body_i : body_i;
        run_s  = {BS{1'b0}};
        hit_s  = 1'b0;
        for (int i = BW - 1; i >= 0; i--) begin
            if (!hit_s) begin
                if (flip_s[i]) begin
                    hit_s = 1'b1;
                end else begin
                    run_s = run_s + {{(BS-1){1'b0}}, 1'b1};
                end
            end else begin
                hit_s = 1'b1;
            end
        end
    end

    // Regime value and field alignment: skip the run plus its terminating bit.
    always_comb begin
        if (lead_s) begin
            k_o = {1'b0, run_s} - {{BS{1'b0}}, 1'b1};
        end else begin
            k_o = {(BS+1){1'b0}} - {1'b0, run_s};
        end
        shamt_s   = {1'b0, run_s} + {{BS{1'b0}}, 1'b1};
        shifted_s = body_i << shamt_s;
        exp_o     = shifted_s[BW-1 -: ES];
        mant_o    = {shifted_s[BW-ES-1:0], 1'b0};
    end

endmodule

// File: rtl/posit_extract_arbiter.sv
// Two-requester round-robin front end feeding a shared 2-stage posit field
// extraction pipeline. Stage 1: special cases, sign, magnitude. Stage 2:
// regime/exponent/mantissa decode. Results carry the source index.
// Optional macro POSIT_ARB_STATS_EN adds saturating per-requester grant counters.
module posit_extract_arbiter
    import posit_extract_arbiter_pkg::*;
#(
    parameter int N  = 16,
    parameter int ES = 2
) (
    input  logic clk,
    input  logic rst,
    posit_extract_arbiter_if.slave bus
`ifdef POSIT_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
`endif
);
    localparam int BS = log2_ceil(N);
    localparam int KW = BS + 1;
    localparam int MW = N - ES;
    localparam logic [63:0]  NAR_W  = nar_pattern(N);
    localparam logic [63:0]  ZERO_W = zero_pattern(N);
    localparam logic [N-2:0] ONE_B  = {{(N-2){1'b0}}, 1'b1};

    // Pipeline control
    logic s1_adv_s;
    logic s2_adv_s;

    // Arbitration
    logic         grant_s;
    logic         accept_s;
    logic         ptr_q;
    logic         ptr_d;
    logic [N-1:0] sel_word_s;
    logic [N-2:0] sel_body_s;

    // Stage 1 registers
    logic         s1_valid_q;
    logic         s1_src_q;
    logic         s1_sign_q;
    logic         s1_zero_q;
    logic         s1_nar_q;
    logic [N-2:0] s1_body_q;

    // Decoder outputs
    logic [KW-1:0] dec_k_s;
    logic [ES-1:0] dec_exp_s;
    logic [MW-1:0] dec_mant_s;

    // Stage 2 / output registers
    logic          out_valid_q;
    logic          out_src_q;
    logic          out_sign_q;
    logic          out_zero_q;
    logic          out_nar_q;
    logic [KW-1:0] out_k_q;
    logic [ES-1:0] out_exp_q;
    logic [MW-1:0] out_mant_q;

    assign s2_adv_s = !out_valid_q || bus.out_ready;
    assign s1_adv_s = !s1_valid_q || s2_adv_s;

    // Grant selection: pointer breaks ties, a lone valid wins outright.
    always_comb begin
        if (bus.in0_valid && bus.in1_valid) begin
            grant_s = ptr_q;
        end else if (bus.in1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        accept_s = s1_adv_s && (bus.in0_valid || bus.in1_valid) && !rst;
        if (accept_s) begin
            ptr_d = ~grant_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    assign bus.in0_ready = accept_s && !grant_s;
    assign bus.in1_ready = accept_s && grant_s;

    // Granted word and its magnitude below the sign bit (two's complement when negative).
    always_comb begin
        sel_word_s = grant_s ? bus.in1_data : bus.in0_data;
        if (sel_word_s[N-1]) begin
            sel_body_s = ~sel_word_s[N-2:0] + ONE_B;
        end else begin
            sel_body_s = sel_word_s[N-2:0];
        end
    end

    // Round-robin pointer: after a transfer the other requester gets priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Stage 1: capture sign, special-case flags and magnitude of the accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_body_q  <= {(N-1){1'b0}};
        end else if (s1_adv_s) begin
            s1_valid_q <= accept_s;
            if (accept_s) begin
                s1_src_q  <= grant_s;
                s1_sign_q <= sel_word_s[N-1];
                s1_zero_q <= (sel_word_s == ZERO_W[N-1:0]);
                s1_nar_q  <= (sel_word_s == NAR_W[N-1:0]);
                s1_body_q <= sel_body_s;
            end
        end
    end

    posit_regime_decode #(
        .N  (N),
        .ES (ES),
        .BS (BS)
    ) u_regime_decode (
        .body_i (s1_body_q),
        .k_o    (dec_k_s),
        .exp_o  (dec_exp_s),
        .mant_o (dec_mant_s)
    );

    // Stage 2: register decoded fields; zero and NaR force the fields to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
            out_sign_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_nar_q   <= 1'b0;
            out_k_q     <= {KW{1'b0}};
            out_exp_q   <= {ES{1'b0}};
            out_mant_q  <= {MW{1'b0}};
        end else if (s2_adv_s) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_src_q  <= s1_src_q;
                out_sign_q <= s1_sign_q;
                out_zero_q <= s1_zero_q;
                out_nar_q  <= s1_nar_q;
                if (s1_zero_q || s1_nar_q) begin
                    out_k_q    <= {KW{1'b0}};
                    out_exp_q  <= {ES{1'b0}};
                    out_mant_q <= {MW{1'b0}};
                end else begin
                    out_k_q    <= dec_k_s;
                    out_exp_q  <= dec_exp_s;
                    out_mant_q <= dec_mant_s;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_nar   = out_nar_q;
    assign bus.out_k     = out_k_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_mant  = out_mant_q;

`ifdef POSIT_ARB_STATS_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    // Per-requester accepted-transfer counters, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else begin
            if (accept_s && !grant_s && (cnt0_q != 16'hFFFF)) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (accept_s && grant_s && (cnt1_q != 16'hFFFF)) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_posit_extract_arbiter.sv
// Directed bench for posit_extract_arbiter with a scoreboard of expected
// decoded results, pushed on each accepted handshake and popped on output.
module tb_posit_extract_arbiter;

    typedef struct packed {
        logic        src;
        logic        sign;
        logic        zero;
        logic        nar;
        logic [4:0]  k;
        logic [1:0]  exp;
        logic [13:0] mant;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    posit_extract_arbiter_if #(.N(16), .ES(2)) bus ();

`ifdef POSIT_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    posit_extract_arbiter #(.N(16), .ES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );
`else
    posit_extract_arbiter #(.N(16), .ES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    res_t sb_q[$];
    logic acc_src_q[$];

    // Reference decode written bit-by-bit from the posit definition.
    function automatic res_t model(input logic [15:0] w, input logic src);
        res_t r;
        logic [15:0] mag;
        logic lead;
        int m;
        int idx;
        r = '0;
        r.src  = src;
        r.sign = w[15];
        r.zero = (w == 16'h0000);
        r.nar  = (w == 16'h8000);
        if (!r.zero && !r.nar) begin
            mag = w[15] ? (16'h0000 - w) : w;
            lead = mag[14];
            m = 0;
            while (m < 15 && mag[14-m] == lead) m++;
            r.k = lead ? 5'(m - 1) : 5'(-m);
            for (int j = 0; j < 2; j++) begin
                idx = 13 - m - j;
                r.exp = {r.exp[0], (idx >= 0) ? mag[idx] : 1'b0};
            end
            for (int j = 0; j < 14; j++) begin
                idx = 11 - m - j;
                r.mant = {r.mant[12:0], (idx >= 0) ? mag[idx] : 1'b0};
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic res_t dut_res();
        return {bus.out_src, bus.out_sign, bus.out_zero, bus.out_nar,
                bus.out_k, bus.out_exp, bus.out_mant};
    endfunction

    // Scoreboard: pop and compare on each output transfer, push on each acceptance.
    always @(negedge clk) begin
        res_t want;
        res_t obs;
        if (rst) begin
            sb_q.delete();
        end else begin
            checks++;
            assert (!(bus.in0_ready && bus.in1_ready)) else begin
                errors++;
                $error("FAIL one_ready: observed both readys high, expected at most one");
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                assert (sb_q.size() > 0) else begin
                    errors++;
                    $error("FAIL sb_empty: observed output src=%0d, expected no output", bus.out_src);
                end
                if (sb_q.size() > 0) begin
                    want = sb_q.pop_front();
                    obs  = dut_res();
                    checks++;
                    assert (obs === want) else begin
                        errors++;
                        $error("FAIL scoreboard: observed %h expected %h", obs, want);
                    end
                end
            end
            if (bus.in0_valid && bus.in0_ready) begin
                sb_q.push_back(model(bus.in0_data, 1'b0));
                acc_src_q.push_back(1'b0);
                acc_cnt++;
            end
            if (bus.in1_valid && bus.in1_ready) begin
                sb_q.push_back(model(bus.in1_data, 1'b1));
                acc_src_q.push_back(1'b1);
                acc_cnt++;
            end
        end
    end

    // Wait (bounded) for the next valid output and compare it with constants.
    task automatic wait_out(input string tag, input res_t want);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, {8'h00, bus.out_valid, dut_res()}, {8'h00, 1'b1, want});
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while ((sb_q.size() != 0 || bus.out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check(tag, sb_q.size(), 32'd0);
    endtask

    task automatic stream(input logic sel, input int count);
        int got;
        int n;
        got = 0;
        n = 0;
        bus.in0_data = 16'h2AAA;
        bus.in1_data = 16'hD555;
        bus.in0_valid = !sel;
        bus.in1_valid = sel;
        while (got < count && n < count * 2 + 100) begin
            @(negedge clk);
            if (sel ? bus.in1_ready : bus.in0_ready) got++;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        check("stream_count", got, count);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] bp_words [6];
        logic [31:0] snap;
        logic        have_snap;
        logic        acc;
        int          idx;
        int          base;
        int          nacc;
        bp_words = '{16'h2468, 16'hA3C1, 16'h6001, 16'h1357, 16'hF00F, 16'h0F0F};

        // Reset state, with both requesters asking
        bus.in0_data = 16'h4000; bus.in1_data = 16'hC000;
        bus.in0_valid = 1'b1; bus.in1_valid = 1'b1; bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_out_fields", dut_res(), 32'd0);
        check("rst_in0_ready", bus.in0_ready, 32'd0);
        check("rst_in1_ready", bus.in1_ready, 32'd0);
        bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: single word, latency and fields
        bus.out_ready = 1'b1;
        bus.in0_data = 16'h4000; bus.in0_valid = 1'b1;
        @(negedge clk);
        check("t1_in0_ready", bus.in0_ready, 32'd1);
        @(posedge clk); #1 bus.in0_valid = 1'b0;
        @(negedge clk);
        check("t1_lat_cycle1", bus.out_valid, 32'd0);
        @(negedge clk);
        check("t1_lat_cycle2", bus.out_valid, 32'd1);
        check("t1_fields", dut_res(), res_t'{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 14'h0});
        drain("t1_drain");

        // 2: contention from a fresh pointer alternates 0,1,0,1
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        acc_src_q.delete();
        fork
            begin
                bus.in0_data = 16'h3000; bus.in1_data = 16'hC000;
                bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
                repeat (4) begin @(posedge clk); #1; end
                bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 2; i++) begin
                    wait_out("t2_res_3000", res_t'{1'b0, 1'b0, 1'b0, 1'b0, 5'h1F, 2'b10, 14'h0});
                    wait_out("t2_res_c000", res_t'{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 14'h0});
                end
            end
        join
        drain("t2_drain");
        check("t2_accepts", acc_src_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < acc_src_q.size(); i++) begin
            check("t2_grant_order", acc_src_q[i], i % 2);
        end

        // 3: special values back to back
        fork
            begin
                bus.in0_valid = 1'b1;
                bus.in0_data = 16'h0000; @(posedge clk); #1;
                bus.in0_data = 16'h8000; @(posedge clk); #1;
                bus.in0_data = 16'h7FFF; @(posedge clk); #1;
                bus.in0_valid = 1'b0;
            end
            begin
                wait_out("t3_zero", res_t'{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 14'h0});
                wait_out("t3_nar", res_t'{1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 2'b00, 14'h0});
                wait_out("t3_maxpos", res_t'{1'b0, 1'b0, 1'b0, 1'b0, 5'd14, 2'b00, 14'h0});
            end
        join
        drain("t3_drain");

        // 4: backpressure for 5 cycles with streaming input
        bus.out_ready = 1'b0;
        idx = 0;
        base = acc_cnt;
        have_snap = 1'b0;
        snap = 32'd0;
        bus.in0_data = bp_words[0]; bus.in0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc = bus.in0_ready;
            if (i >= 2) begin
                check("t4_in0_ready_low", bus.in0_ready, 32'd0);
                check("t4_in1_ready_low", bus.in1_ready, 32'd0);
            end
            if (have_snap) begin
                check("t4_hold", {8'h00, bus.out_valid, dut_res()}, snap);
            end else if (bus.out_valid) begin
                snap = {8'h00, bus.out_valid, dut_res()};
                have_snap = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) begin idx++; bus.in0_data = bp_words[idx]; end
        end
        check("t4_accepted", acc_cnt - base, 32'd2);
        check("t4_held_valid", have_snap, 32'd1);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 30 && idx < 6; n++) begin
            @(negedge clk);
            acc = bus.in0_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 6) bus.in0_data = bp_words[idx];
            end
        end
        bus.in0_valid = 1'b0;
        drain("t4_drain");
        check("t4_total", acc_cnt - base, 32'd6);

        // 5: reset with both stages full, then pointer back to requester 0
        bus.out_ready = 1'b0;
        nacc = 0;
        bus.in0_data = 16'h1111; bus.in0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.in0_ready) nacc++;
            @(posedge clk); #1;
            if (nacc == 1) bus.in0_data = 16'h2222;
            if (nacc == 2) bus.in0_valid = 1'b0;
        end
        check("t5_full_valid", bus.out_valid, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", bus.out_valid, 32'd0);
        bus.in0_data = 16'h4000; bus.in1_data = 16'hC000;
        bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
        #1;
        check("t5_rst_ready0", bus.in0_ready, 32'd0);
        check("t5_rst_ready1", bus.in1_ready, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t5_ptr_in0", bus.in0_ready, 32'd1);
        check("t5_ptr_in1", bus.in1_ready, 32'd0);
        @(posedge clk); #1;
        bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
        wait_out("t5_first", res_t'{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 14'h0});
        drain("t5_drain");

`ifdef POSIT_ARB_STATS_EN
        // 6: grant counters, requester 1 saturating
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("t6_cnt0_rst", grant_cnt0, 32'd0);
        stream(1'b0, 300);
        stream(1'b1, 70000);
        drain("t6_drain");
        check("t6_cnt0", grant_cnt0, 32'd300);
        check("t6_cnt1", grant_cnt1, 32'h0000FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
